// File: rtl/or_unit_pkg.sv
// Shared limits and helpers for the registered OR unit.
// or_reduce takes a zero-extended vector so any legal width can use it.
package or_unit_pkg;

  localparam int OR_MAX_WIDTH  = 64;
  localparam int OR_MAX_STAGES = 4;

  function automatic logic or_reduce(input logic [OR_MAX_WIDTH-1:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/or_pipe_stage.sv
// One register slice of the OR pipeline: {data, valid} with async active-high clear.
module or_pipe_stage
  import or_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // NOTE: non-blocking assignments keep every slice sampling its
  // predecessor's old value on the same edge, which is what makes a chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= in_data;
      valid <= in_valid;
    end
  end

endmodule

// File: rtl/or_unit.sv
// Registered two-operand bitwise OR with valid qualifier and reduction-OR flag.
// PIPE_STAGES slices follow the OR; PIPE_STAGES=0 is a purely combinational path.
module or_unit
  import or_unit_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             any_set
);

  if (WIDTH < 1 || WIDTH > OR_MAX_WIDTH) begin : g_bad_width
    $error("or_unit: WIDTH=%0d outside 1..%0d", WIDTH, OR_MAX_WIDTH);
  end
  if (PIPE_STAGES < 0 || PIPE_STAGES > OR_MAX_STAGES) begin : g_bad_stages
    $error("or_unit: PIPE_STAGES=%0d outside 0..%0d", PIPE_STAGES, OR_MAX_STAGES);
  end

  logic [WIDTH-1:0] or_data;
  assign or_data = in1 | in2;

  if (PIPE_STAGES == 0) begin : g_bypass
    // Clock and reset are deliberately inert without registers.
    logic unused_clocking;
    assign unused_clocking = clk ^ rst;
    assign out             = or_data;
    assign out_valid       = in_valid;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_chain  [0:PIPE_STAGES];
    logic             valid_chain [0:PIPE_STAGES];

    assign data_chain[0]  = or_data;
    assign valid_chain[0] = in_valid;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      or_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .in_data  (data_chain[s]),
        .in_valid (valid_chain[s]),
        .data     (data_chain[s+1]),
        .valid    (valid_chain[s+1])
      );
    end

    assign out       = data_chain[PIPE_STAGES];
    assign out_valid = valid_chain[PIPE_STAGES];
  end

  // Taken from the final stage so the flag never lags the data.
  assign any_set = or_reduce(OR_MAX_WIDTH'(out));

endmodule

// File: tb/tb_or_unit.sv
// Scoreboard bench for or_unit across several WIDTH/PIPE_STAGES configurations.
// Stimulus pushes expected results; a negedge monitor pops and compares them.
module tb_or_unit;

  localparam int NI = 5;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb [NI][$];
  exp_t        mon_e;
  int          wid [NI];
  int          lat [NI];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a [NI];
  logic [63:0] b [NI];
  logic        v [NI];
  logic [63:0] got_d [NI];
  logic        got_v [NI];
  logic        got_any [NI];

  logic [0:0]  o0;
  logic [7:0]  o1, o2;
  logic [3:0]  o3;
  logic [63:0] o4;

  logic [3:0]  a0p, b0p, oz;
  logic        v0p, vz, anyz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  or_unit #(.WIDTH(1), .PIPE_STAGES(1)) u_w1p1 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in1(a[0][0:0]), .in2(b[0][0:0]),
    .out(o0), .out_valid(got_v[0]), .any_set(got_any[0]));
  or_unit #(.WIDTH(8), .PIPE_STAGES(2)) u_w8p2 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in1(a[1][7:0]), .in2(b[1][7:0]),
    .out(o1), .out_valid(got_v[1]), .any_set(got_any[1]));
  or_unit #(.WIDTH(8), .PIPE_STAGES(1)) u_w8p1 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in1(a[2][7:0]), .in2(b[2][7:0]),
    .out(o2), .out_valid(got_v[2]), .any_set(got_any[2]));
  or_unit #(.WIDTH(4), .PIPE_STAGES(3)) u_w4p3 (
    .clk(clk), .rst(rst), .in_valid(v[3]), .in1(a[3][3:0]), .in2(b[3][3:0]),
    .out(o3), .out_valid(got_v[3]), .any_set(got_any[3]));
  or_unit #(.WIDTH(64), .PIPE_STAGES(4)) u_w64p4 (
    .clk(clk), .rst(rst), .in_valid(v[4]), .in1(a[4]), .in2(b[4]),
    .out(o4), .out_valid(got_v[4]), .any_set(got_any[4]));
  or_unit #(.WIDTH(4), .PIPE_STAGES(0)) u_w4p0 (
    .clk(clk), .rst(rst), .in_valid(v0p), .in1(a0p), .in2(b0p),
    .out(oz), .out_valid(vz), .any_set(anyz));

  assign got_d[0] = 64'(o0);
  assign got_d[1] = 64'(o1);
  assign got_d[2] = 64'(o2);
  assign got_d[3] = 64'(o3);
  assign got_d[4] = o4;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] msk(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic set_in(input int i, input logic [63:0] x, input logic [63:0] y, input logic vv);
    a[i] = x & msk(wid[i]);
    b[i] = y & msk(wid[i]);
    v[i] = vv;
  endtask

  // Combinational instance: result must be present right after inputs settle.
  task automatic check_comb();
    logic [3:0] e;
    e = a0p | b0p;
    check("p0_out", 64'(oz), 64'(e));
    check("p0_any", 64'(anyz), 64'(e != 4'd0));
    check("p0_valid", 64'(vz), 64'(v0p));
  endtask

  // Reference model: a valid pair issued now shows up lat cycles later as a|b.
  task automatic cycle();
    #1 check_comb();
    for (int i = 0; i < NI; i++)
      if (v[i]) sb[i].push_back('{data: a[i] | b[i], due: cyc + lat[i]});
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) v[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("rst_out_u%0d", i), got_d[i], 64'd0);
        check($sformatf("rst_valid_u%0d", i), 64'(got_v[i]), 64'd0);
        check($sformatf("rst_any_u%0d", i), 64'(got_any[i]), 64'd0);
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (got_v[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("spurious_valid_u%0d", i), 64'd1, 64'd0);
          end else begin
            mon_e = sb[i].pop_front();
            check($sformatf("data_u%0d", i), got_d[i], mon_e.data);
            check($sformatf("any_u%0d", i), 64'(got_any[i]), 64'(mon_e.data != 64'd0));
            check($sformatf("latency_u%0d", i), 64'(cyc), 64'(mon_e.due));
          end
        end else if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
          check($sformatf("missing_valid_u%0d", i), 64'd0, 64'd1);
          void'(sb[i].pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    wid = '{1, 8, 8, 4, 64};
    lat = '{1, 2, 1, 3, 4};
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      a[i] = '0; b[i] = '0; v[i] = 1'b0;
    end
    a0p = '0; b0p = '0; v0p = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_out_u%0d", i), got_d[i], 64'd0);
      check($sformatf("reset_valid_u%0d", i), 64'(got_v[i]), 64'd0);
    end
    rst = 1'b0;
    cycle();

    // 1-bit OR truth table, each pattern held 100 ns.
    for (int p = 0; p < 4; p++) begin
      set_in(0, 64'((p >> 1) & 1), 64'(p & 1), 1'b1);
      repeat (10) cycle();
    end

    // Asynchronous reset while out=1.
    set_in(0, 64'd1, 64'd0, 1'b1);
    cycle();
    check("pre_rst_out", got_d[0], 64'd1);
    idle_all();
    #1 rst = 1'b1;
    #1;
    check("async_rst_out", got_d[0], 64'd0);
    check("async_rst_valid", 64'(got_v[0]), 64'd0);
    check("async_rst_any", 64'(got_any[0]), 64'd0);
    for (int i = 0; i < NI; i++) sb[i].delete();
    @(posedge clk);
    #2;
    set_in(0, 64'd1, 64'd1, 1'b1);
    rst = 1'b0;
    #1;
    check("post_release_out", got_d[0], 64'd0);
    check("post_release_valid", 64'(got_v[0]), 64'd0);
    cycle();
    check("first_after_release", got_d[0], 64'd1);
    idle_all();
    cycle();

    // Two-stage 8-bit: A0|05 then 00|00.
    set_in(1, 64'hA0, 64'h05, 1'b1);
    cycle();
    set_in(1, 64'h00, 64'h00, 1'b1);
    cycle();
    idle_all();
    repeat (3) cycle();

    // Invalid slot still loads data; next valid slot qualified.
    set_in(2, 64'hFF, 64'h00, 1'b0);
    cycle();
    set_in(2, 64'h0F, 64'hF0, 1'b1);
    check("invalid_slot_data", got_d[2], 64'hFF);
    check("invalid_slot_valid", 64'(got_v[2]), 64'd0);
    cycle();
    idle_all();
    repeat (2) cycle();

    // Combinational instance with directed operands.
    a0p = 4'b1000; b0p = 4'b0001; v0p = 1'b1;
    #1;
    check("p0_direct_out", 64'(oz), 64'h9);
    check("p0_direct_any", 64'(anyz), 64'd1);
    check("p0_direct_valid", 64'(vz), 64'd1);
    v0p = 1'b0;
    #1 check("p0_direct_invalid", 64'(vz), 64'd0);

    // Five back-to-back pairs through three stages.
    for (int k = 0; k < 5; k++) begin
      set_in(3, 64'($urandom_range(15)), 64'($urandom_range(15)), 1'b1);
      cycle();
    end
    idle_all();
    repeat (5) cycle();

    // Randomised traffic on every configuration.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NI; i++)
        set_in(i, {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(3) != 0));
      a0p = 4'($urandom_range(15));
      b0p = 4'($urandom_range(15));
      v0p = 1'($urandom_range(1));
      cycle();
    end

    idle_all();
    v0p = 1'b0;
    repeat (8) cycle();
    for (int i = 0; i < NI; i++)
      check($sformatf("drained_u%0d", i), 64'(sb[i].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
